// File: rtl/bird_pkg.sv
// Shared definitions for the bird launch path: FSM state encoding, frame
// timing constants and the plane X launch window shared with bird_move.
package bird_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READY    = 3'd1,
      ST_ARM      = 3'd2,
      ST_FLIGHT   = 3'd3,
      ST_COOLDOWN = 3'd4,
      ST_DONE     = 3'd5
   } launch_state_t;

   localparam int FRAMES_PER_SEC    = 30;
   localparam int DEF_PLANE_X_LIMIT = 290;
   localparam int FRAME_CNT_W       = 10;

endpackage

// File: rtl/frame_timer.sv
// Frame counter: clears on request, counts startOfFrame pulses, and flags
// the pulse that brings the count up to the supplied limit.
module frame_timer
   import bird_pkg::*;
#(
   parameter int W = FRAME_CNT_W
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_inc;

   // Next count; clear beats increment so an entry-cycle frame is never counted.
   always_comb begin
      cnt_inc = cnt_q + W'(1);
      cnt_d   = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_inc;
      end
   end

   // Compare is against the post-increment value: limit N fires on the Nth pulse.
   assign expired = en && (cnt_inc == limit);

   // Counter register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bird_launch_ctrl.sv
// Per-level bird launch scheduler between the game manager and bird_move.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | no level running, all outputs low
//   READY       | waiting for a pending launch on an in-range frame
//   ARM         | showBird high, waiting for bird_move to display the bird
//   FLIGHT      | bird on screen, flight timeout running
//   COOLDOWN    | bird ended, re-launch holdoff running
//   DONE        | budget exhausted, levelOver held until next levelStart
module bird_launch_ctrl
   import bird_pkg::*;
#(
   parameter int BIRDS_PER_LEVEL    = 5,
   parameter int COOLDOWN_FRAMES    = FRAMES_PER_SEC / 2,
   parameter int MAX_FLIGHT_FRAMES  = 10 * FRAMES_PER_SEC,
   parameter int ARM_TIMEOUT_FRAMES = 2 * FRAMES_PER_SEC,
   parameter int PLANE_X_LIMIT      = DEF_PLANE_X_LIMIT
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        levelStart,
   input  logic        launchReq,
   input  logic [10:0] planeTopLeftX,
   input  logic        displayBird,
   input  logic        hideBirdPulse,
   output logic        showBird,
   output logic [3:0]  birdsLeft,
   output logic        birdInFlight,
   output logic        forceHide,
   output logic        levelOver
);

   launch_state_t state_q, state_d;
   logic [3:0]    birds_left_q, birds_left_d;
   logic          pending_q, pending_d;
   logic          show_bird_q, show_bird_d;
   logic          in_flight_q, in_flight_d;
   logic          force_hide_q, force_hide_d;
   logic          level_over_q, level_over_d;

   logic                   tmr_clr;
   logic                   tmr_en;
   logic                   tmr_expired;
   logic [FRAME_CNT_W-1:0] tmr_limit;
   logic                   plane_in_range;

   assign plane_in_range = (planeTopLeftX <= 11'(PLANE_X_LIMIT));

   // One shared timer; its limit follows the state that is currently timing.
   always_comb begin
      tmr_limit = '0;
      case (state_q)
         ST_ARM:      tmr_limit = FRAME_CNT_W'(ARM_TIMEOUT_FRAMES);
         ST_FLIGHT:   tmr_limit = FRAME_CNT_W'(MAX_FLIGHT_FRAMES);
         ST_COOLDOWN: tmr_limit = FRAME_CNT_W'(COOLDOWN_FRAMES);
         default:     tmr_limit = '0;
      endcase
   end

   assign tmr_en  = startOfFrame &&
                    ((state_q == ST_ARM) || (state_q == ST_FLIGHT) || (state_q == ST_COOLDOWN));
   assign tmr_clr = levelStart || (state_d != state_q);

   frame_timer #(
      .W (FRAME_CNT_W)
   ) u_frame_timer (
      .clk     (clk),
      .resetN  (resetN),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .limit   (tmr_limit),
      .expired (tmr_expired)
   );

   // Next-state, budget and pending logic; outputs decode the next state so they register with it.
   always_comb begin
      state_d      = state_q;
      birds_left_d = birds_left_q;
      pending_d    = pending_q;
      force_hide_d = 1'b0;

      if (levelStart) begin
         state_d      = ST_READY;
         birds_left_d = 4'(BIRDS_PER_LEVEL);
         pending_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
            end
            ST_READY: begin
               if (startOfFrame && (pending_q || launchReq) && plane_in_range) begin
                  state_d   = ST_ARM;
                  pending_d = 1'b0;
               end else if (launchReq) begin
                  pending_d = 1'b1;
               end
            end
            ST_ARM: begin
               // A hide before display means the bird never flew: no charge.
               if (hideBirdPulse) begin
                  state_d = ST_COOLDOWN;
               end else if (displayBird) begin
                  state_d = ST_FLIGHT;
                  if (birds_left_q != 4'd0) begin
                     birds_left_d = birds_left_q - 4'd1;
                  end
               end else if (tmr_expired) begin
                  state_d   = ST_READY;
                  pending_d = 1'b0;
               end
            end
            ST_FLIGHT: begin
               if (hideBirdPulse) begin
                  state_d = ST_COOLDOWN;
               end else if (tmr_expired) begin
                  state_d      = ST_COOLDOWN;
                  force_hide_d = 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (tmr_expired) begin
                  state_d = (birds_left_q == 4'd0) ? ST_DONE : ST_READY;
               end
            end
            ST_DONE: begin
            end
            default: state_d = ST_IDLE;
         endcase
      end

      show_bird_d  = (state_d == ST_ARM);
      in_flight_d  = (state_d == ST_FLIGHT);
      level_over_d = (state_d == ST_DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ST_IDLE;
         birds_left_q <= 4'd0;
         pending_q    <= 1'b0;
         show_bird_q  <= 1'b0;
         in_flight_q  <= 1'b0;
         force_hide_q <= 1'b0;
         level_over_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         birds_left_q <= birds_left_d;
         pending_q    <= pending_d;
         show_bird_q  <= show_bird_d;
         in_flight_q  <= in_flight_d;
         force_hide_q <= force_hide_d;
         level_over_q <= level_over_d;
      end
   end

   assign showBird     = show_bird_q;
   assign birdsLeft    = birds_left_q;
   assign birdInFlight = in_flight_q;
   assign forceHide    = force_hide_q;
   assign levelOver    = level_over_q;

endmodule

// File: tb/tb_bird_launch_ctrl.sv
// Bench for bird_launch_ctrl: frame-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed frame counts.
module tb_bird_launch_ctrl;

   localparam int L_BIRDS = 5;
   localparam int L_COOL  = 15;
   localparam int L_FLY   = 300;
   localparam int L_ARM   = 60;
   localparam int L_XLIM  = 290;

   localparam int M_IDLE   = 0;
   localparam int M_READY  = 1;
   localparam int M_ARM    = 2;
   localparam int M_FLIGHT = 3;
   localparam int M_COOL   = 4;
   localparam int M_DONE   = 5;

   logic        clk    = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame  = 1'b0;
   logic        levelStart    = 1'b0;
   logic        launchReq     = 1'b0;
   logic [10:0] planeTopLeftX = 11'd100;
   logic        displayBird   = 1'b0;
   logic        hideBirdPulse = 1'b0;
   logic        showBird;
   logic [3:0]  birdsLeft;
   logic        birdInFlight;
   logic        forceHide;
   logic        levelOver;

   int n_tests = 0;
   int n_fail  = 0;

   int   m_mode   = M_IDLE;
   int   m_frames = 0;
   int   m_left   = 0;
   logic m_pend   = 1'b0;
   logic m_fh     = 1'b0;

   always #5 clk = ~clk;

   bird_launch_ctrl #(
      .BIRDS_PER_LEVEL    (L_BIRDS),
      .COOLDOWN_FRAMES    (L_COOL),
      .MAX_FLIGHT_FRAMES  (L_FLY),
      .ARM_TIMEOUT_FRAMES (L_ARM),
      .PLANE_X_LIMIT      (L_XLIM)
   ) dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .levelStart    (levelStart),
      .launchReq     (launchReq),
      .planeTopLeftX (planeTopLeftX),
      .displayBird   (displayBird),
      .hideBirdPulse (hideBirdPulse),
      .showBird      (showBird),
      .birdsLeft     (birdsLeft),
      .birdInFlight  (birdInFlight),
      .forceHide     (forceHide),
      .levelOver     (levelOver)
   );

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: mode plus frames-since-entry, updated once per clock.
   always @(posedge clk or negedge resetN) begin : model
      int   mode;
      int   frames;
      int   left;
      logic pend;
      logic fh;
      if (!resetN) begin
         m_mode   <= M_IDLE;
         m_frames <= 0;
         m_left   <= 0;
         m_pend   <= 1'b0;
         m_fh     <= 1'b0;
      end else begin
         mode   = m_mode;
         frames = m_frames;
         left   = m_left;
         pend   = m_pend;
         fh     = 1'b0;
         if (levelStart) begin
            mode = M_READY; frames = 0; left = L_BIRDS; pend = 1'b0;
         end else begin
            case (mode)
               M_READY: begin
                  if (startOfFrame && (pend || launchReq) && (int'(planeTopLeftX) <= L_XLIM)) begin
                     mode = M_ARM; frames = 0; pend = 1'b0;
                  end else if (launchReq) begin
                     pend = 1'b1;
                  end
               end
               M_ARM: begin
                  if (hideBirdPulse) begin
                     mode = M_COOL; frames = 0;
                  end else if (displayBird) begin
                     mode = M_FLIGHT; frames = 0;
                     if (left > 0) left = left - 1;
                  end else if (startOfFrame) begin
                     frames = frames + 1;
                     if (frames == L_ARM) begin mode = M_READY; frames = 0; end
                  end
               end
               M_FLIGHT: begin
                  if (hideBirdPulse) begin
                     mode = M_COOL; frames = 0;
                  end else if (startOfFrame) begin
                     frames = frames + 1;
                     if (frames == L_FLY) begin mode = M_COOL; frames = 0; fh = 1'b1; end
                  end
               end
               M_COOL: begin
                  if (startOfFrame) begin
                     frames = frames + 1;
                     if (frames == L_COOL) begin
                        mode = (left == 0) ? M_DONE : M_READY; frames = 0;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
         m_mode   <= mode;
         m_frames <= frames;
         m_left   <= left;
         m_pend   <= pend;
         m_fh     <= fh;
      end
   end

   // Every-cycle comparison against the model, just after the active edge.
   always @(posedge clk) begin
      #1;
      check("m_showBird",     showBird,     (m_mode == M_ARM));
      check("m_birdInFlight", birdInFlight, (m_mode == M_FLIGHT));
      check("m_levelOver",    levelOver,    (m_mode == M_DONE));
      check("m_forceHide",    forceHide,    m_fh);
      check("m_birdsLeft",    birdsLeft,    m_left);
   end

   task automatic tick(input logic s, input logic ls, input logic lr, input logic h);
      @(negedge clk);
      startOfFrame  = s;
      levelStart    = ls;
      launchReq     = lr;
      hideBirdPulse = h;
   endtask

   task automatic idle3();
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle3();
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   // Frames (each carrying launchReq) until showBird or levelOver rises; 0 if never.
   task automatic launch_loop(output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0);
         sample();
         if (showBird || levelOver) begin
            n = i;
            break;
         end
         idle3();
      end
   endtask

   task automatic fly_and_land();
      displayBird = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) frame();
      displayBird = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      check("rst_showBird",  showBird,  0);
      check("rst_birdsLeft", birdsLeft, 0);
      check("rst_levelOver", levelOver, 0);
      resetN = 1'b1;

      // Level start and first launch
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      check("ls_birdsLeft", birdsLeft, 5);
      planeTopLeftX = 11'd100;
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      sample();
      check("launch_showBird", showBird, 1);
      displayBird = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      check("disp_birdsLeft", birdsLeft, 4);
      check("disp_inFlight",  birdInFlight, 1);
      check("disp_showBird",  showBird, 0);
      repeat (5) frame();
      displayBird = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      launch_loop(n);
      check("cool_then_launch_frames", n, 16);

      // ARM timeout: displayBird stays low
      n = 0;
      for (int i = 1; i <= 80; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         sample();
         if (!showBird) begin n = i; break; end
         idle3();
      end
      check("arm_timeout_frames", n, 60);
      check("arm_timeout_left", birdsLeft, 4);

      // Plane out of range keeps the request pending
      planeTopLeftX = 11'd400;
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (10) frame();
      check("out_of_range_show", showBird, 0);
      planeTopLeftX = 11'd200;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      sample();
      check("pending_launch_show", showBird, 1);

      // Flight timeout
      displayBird = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      check("fly3_birdsLeft", birdsLeft, 3);
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         sample();
         if (forceHide) begin n = i; break; end
         idle3();
      end
      check("flight_timeout_frames", n, 300);
      displayBird = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      check("forceHide_width", forceHide, 0);
      check("after_timeout_inFlight", birdInFlight, 0);
      launch_loop(n);
      check("timeout_cool_launch_frames", n, 16);

      // Hide coincides with the 300th flight frame
      displayBird = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      check("fly4_birdsLeft", birdsLeft, 2);
      repeat (299) frame();
      displayBird = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      sample();
      check("hide_wins_forceHide", forceHide, 0);
      check("hide_wins_inFlight", birdInFlight, 0);
      launch_loop(n);
      check("hide_cool_launch_frames", n, 16);

      // Spend the rest of the budget
      fly_and_land();
      check("fly5_birdsLeft", birdsLeft, 1);
      launch_loop(n);
      check("launch6_frames", n, 16);
      fly_and_land();
      check("fly6_birdsLeft", birdsLeft, 0);
      launch_loop(n);
      check("done_after_cool_frames", n, 15);
      check("done_levelOver", levelOver, 1);
      check("done_showBird", showBird, 0);
      repeat (3) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0);
         idle3();
      end
      sample();
      check("done_ignores_launch", showBird, 0);
      check("done_held", levelOver, 1);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      sample();
      check("relevel_birdsLeft", birdsLeft, 5);
      check("relevel_levelOver", levelOver, 0);

      // levelStart on the frame that would time out the flight
      launch_loop(n);
      check("ready_same_cycle_launch", n, 1);
      displayBird = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (299) frame();
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      sample();
      check("ls_flight_forceHide", forceHide, 0);
      check("ls_flight_birdsLeft", birdsLeft, 5);
      check("ls_flight_inFlight", birdInFlight, 0);
      displayBird = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);

      // Async reset mid-ARM
      launch_loop(n);
      check("arm_before_reset", showBird, 1);
      @(negedge clk);
      #2;
      resetN = 1'b0;
      #1;
      check("async_rst_showBird",  showBird,  0);
      check("async_rst_birdsLeft", birdsLeft, 0);
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
      sample();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
